// File: rtl/xadc_scan_pkg.sv
// Shared types and DRP address constants for the XADC auxiliary-channel scanner.
package xadc_scan_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam logic [6:0] VAUX6  = 7'h16;
  localparam logic [6:0] VAUX7  = 7'h17;
  localparam logic [6:0] VAUX14 = 7'h1E;
  localparam logic [6:0] VAUX15 = 7'h1F;

  // Channel 0 sits in the low 7 bits.
  localparam logic [27:0] DEF_CH_ADDRS = {VAUX15, VAUX14, VAUX7, VAUX6};

endpackage

// File: rtl/pwm_channel.sv
// One PWM output: duty shadow register reloaded at the counter wrap, plus comparator.
module pwm_channel #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] pwm_count,
  input  logic [DATA_W-1:0] sample,
  output logic              pwm_out
);

  logic [DATA_W-1:0] duty_reg;

  // Reload only at the start of a period so an edge never moves mid-period.
  always_ff @(posedge clk) begin
    if (rst) begin
      duty_reg <= '0;
    end else if (pwm_count == '0) begin
      duty_reg <= sample;
    end
  end

  assign pwm_out = (pwm_count <= duty_reg);

endmodule

// File: rtl/xadc_scan_pwm.sv
// XADC DRP round-robin scanner driving one PWM output per channel.
// Define XADC_SCAN_AVG_EN to average 2^AVG_LOG2 captures per channel before publishing.
module xadc_scan_pwm
  import xadc_scan_pkg::*;
#(
  parameter int                  NUM_CH   = 4,
  parameter int                  DATA_W   = 8,
  parameter logic [NUM_CH*7-1:0] CH_ADDRS = DEF_CH_ADDRS,
  parameter int                  TIMEOUT  = 255,
  parameter int                  AVG_LOG2 = 2,
  localparam int                 CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              eoc,
  input  logic              drdy,
  input  logic [15:0]       dout,
  output logic              den,
  output logic [6:0]        daddr,
  output logic [DATA_W-1:0] sample_data,
  output logic [CH_W-1:0]   sample_ch,
  output logic              sample_valid,
  output logic              timeout_err,
  output logic [NUM_CH-1:0] pwm_out
);

  localparam int TO_W = $clog2(TIMEOUT + 1);

  state_t            state_reg, state_next;
  logic [CH_W-1:0]   idx_reg;
  logic [TO_W-1:0]   wait_cnt_reg;
  logic [DATA_W-1:0] pwm_count_reg;
  logic [DATA_W-1:0] sample_reg [NUM_CH];
  logic [DATA_W-1:0] cap_bits;
  logic              capture, expire;
  logic              unused_bits;

  assign cap_bits    = dout[15 -: DATA_W];
  assign unused_bits = ^{dout, AVG_LOG2[0]};

  // drdy wins over an expiring timer on the same cycle.
  assign capture = (state_reg == WAIT) && drdy;
  assign expire  = (state_reg == WAIT) && !drdy && (wait_cnt_reg == TO_W'(TIMEOUT - 1));
  assign den     = (state_reg == REQ);

`ifdef XADC_SCAN_AVG_EN
  localparam int AW = DATA_W + AVG_LOG2;
  localparam int NW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

  logic [AW-1:0] acc_reg [NUM_CH];
  logic [NW-1:0] n_reg   [NUM_CH];
  logic [AW-1:0] acc_sum;
  logic          acc_full;

  assign acc_sum  = acc_reg[idx_reg] + AW'(cap_bits);
  assign acc_full = (n_reg[idx_reg] == NW'((1 << AVG_LOG2) - 1));
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (eoc) state_next = REQ;
      REQ:     state_next = WAIT;
      WAIT:    if (capture || expire) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_reg       <= '0;
      wait_cnt_reg  <= '0;
      pwm_count_reg <= '0;
      daddr         <= CH_ADDRS[6:0];
      sample_data   <= '0;
      sample_ch     <= '0;
      sample_valid  <= 1'b0;
      timeout_err   <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        sample_reg[i] <= '0;
`ifdef XADC_SCAN_AVG_EN
        acc_reg[i]    <= '0;
        n_reg[i]      <= '0;
`endif
      end
    end else begin
      pwm_count_reg <= pwm_count_reg + 1'b1;
      sample_valid  <= 1'b0;
      timeout_err   <= 1'b0;

      // Address tracks idx only while idle, so it is stable across den and the wait.
      if (state_reg == IDLE) begin
        daddr <= CH_ADDRS[7*idx_reg +: 7];
      end

      if (state_reg == REQ) begin
        wait_cnt_reg <= '0;
      end else if (state_reg == WAIT) begin
        wait_cnt_reg <= wait_cnt_reg + 1'b1;
      end

      if (expire) begin
        timeout_err <= 1'b1;
      end

      if (capture) begin
        idx_reg <= (idx_reg == CH_W'(NUM_CH - 1)) ? '0 : idx_reg + 1'b1;
`ifdef XADC_SCAN_AVG_EN
        if (acc_full) begin
          sample_reg[idx_reg] <= acc_sum[AW-1 -: DATA_W];
          sample_data         <= acc_sum[AW-1 -: DATA_W];
          sample_ch           <= idx_reg;
          sample_valid        <= 1'b1;
          acc_reg[idx_reg]    <= '0;
          n_reg[idx_reg]      <= '0;
        end else begin
          acc_reg[idx_reg]    <= acc_sum;
          n_reg[idx_reg]      <= n_reg[idx_reg] + 1'b1;
        end
`else
        sample_reg[idx_reg] <= cap_bits;
        sample_data         <= cap_bits;
        sample_ch           <= idx_reg;
        sample_valid        <= 1'b1;
`endif
      end
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_pwm
    pwm_channel #(
      .DATA_W(DATA_W)
    ) u_pwm (
      .clk      (clk),
      .rst      (rst),
      .pwm_count(pwm_count_reg),
      .sample   (sample_reg[gi]),
      .pwm_out  (pwm_out[gi])
    );
  end

endmodule

// File: tb/tb_xadc_scan_pwm.sv
// Randomised self-checking bench for xadc_scan_pwm against a behavioural scan/PWM model.
module tb_xadc_scan_pwm;

  localparam int NUM_CH   = 4;
  localparam int TIMEOUT  = 255;
  localparam int AVG_LOG2 = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        eoc = 1'b0;
  logic        drdy = 1'b0;
  logic [15:0] dout = 16'h0;
  logic        den;
  logic [6:0]  daddr;
  logic [7:0]  sample_data;
  logic [1:0]  sample_ch;
  logic        sample_valid;
  logic        timeout_err;
  logic [3:0]  pwm_out;

  always #5 clk = ~clk;

  xadc_scan_pwm dut (
    .clk         (clk),
    .rst         (rst),
    .eoc         (eoc),
    .drdy        (drdy),
    .dout        (dout),
    .den         (den),
    .daddr       (daddr),
    .sample_data (sample_data),
    .sample_ch   (sample_ch),
    .sample_valid(sample_valid),
    .timeout_err (timeout_err),
    .pwm_out     (pwm_out)
  );

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  logic [6:0] addr_tab [NUM_CH] = '{7'h16, 7'h17, 7'h1E, 7'h1F};
  int         model_idx;
  logic [7:0] model_sample [NUM_CH];
  logic [7:0] model_data;
  int         model_ch;
  int         model_acc [NUM_CH];
  int         model_n [NUM_CH];

  // Passive monitors
  int         den_cnt = 0, sv_cnt = 0, to_cnt = 0, periods = 0;
  logic [7:0] tb_pwm = 8'd0;
  int         per_hi [NUM_CH];
  int         per_snap [NUM_CH];
  int         last_hi [NUM_CH];
  int         last_exp [NUM_CH];

  always @(posedge clk) tb_pwm <= rst ? 8'd0 : tb_pwm + 8'd1;

  always @(negedge clk) begin
    if (den) den_cnt++;
    if (sample_valid) sv_cnt++;
    if (timeout_err) to_cnt++;
    for (int i = 0; i < NUM_CH; i++) begin
      if (tb_pwm == 8'd0) per_hi[i] = int'(pwm_out[i]);
      else per_hi[i] += int'(pwm_out[i]);
      // Duty taken at the wrap edge equals the sample held once the count reaches 1.
      if (tb_pwm == 8'd1) per_snap[i] = int'(model_sample[i]);
    end
    if (tb_pwm == 8'd255) begin
      for (int i = 0; i < NUM_CH; i++) begin
        last_hi[i]  = per_hi[i];
        last_exp[i] = per_snap[i] + 1;
      end
      periods++;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic model_reset;
    model_idx  = 0;
    model_data = 8'h00;
    model_ch   = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      model_sample[i] = 8'h00;
      model_acc[i]    = 0;
      model_n[i]      = 0;
    end
  endtask

  task automatic model_cap(input logic [15:0] d, output bit strobe);
    logic [7:0] s;
    s = d[15:8];
    strobe = 1'b0;
`ifdef XADC_SCAN_AVG_EN
    model_acc[model_idx] += int'(s);
    model_n[model_idx]++;
    if (model_n[model_idx] == (1 << AVG_LOG2)) begin
      model_sample[model_idx] = 8'(model_acc[model_idx] >> AVG_LOG2);
      model_data = model_sample[model_idx];
      model_ch   = model_idx;
      strobe     = 1'b1;
      model_acc[model_idx] = 0;
      model_n[model_idx]   = 0;
    end
`else
    model_sample[model_idx] = s;
    model_data = s;
    model_ch   = model_idx;
    strobe     = 1'b1;
`endif
    model_idx = (model_idx + 1) % NUM_CH;
  endtask

  task automatic do_reset;
    rst = 1'b1; eoc = 1'b0; drdy = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    model_reset();
  endtask

  // Drives one eoc/den/drdy round; returns in the cycle after drdy (or after den if !send).
  task automatic run_txn(input logic [15:0] d, input int delay, input bit send, input bit spam,
                         output logic [6:0] addr_seen, output int den_w);
    int g;
    eoc = 1'b1; tick(); eoc = 1'b0;
    g = 0;
    while (!den && g < 8) begin tick(); g++; end
    addr_seen = daddr;
    den_w = 0;
    while (den && den_w < 8) begin den_w++; tick(); end
    if (send) begin
      for (int i = 1; i < delay; i++) begin
        if (spam) eoc = 1'($urandom_range(0, 1));
        tick();
      end
      eoc = 1'b0; drdy = 1'b1; dout = d;
      tick();
      drdy = 1'b0; dout = 16'($urandom);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) tick();
    checks++; if (den !== 1'b0) begin errors++; $display("FAIL reset_den got=%b want=0", den); end
    checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", sample_valid); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_tmo got=%b want=0", timeout_err); end
    checks++; if (sample_data !== 8'h00) begin errors++; $display("FAIL reset_data got=%h want=00", sample_data); end
    checks++; if (sample_ch !== 2'd0) begin errors++; $display("FAIL reset_ch got=%0d want=0", sample_ch); end
    checks++; if (pwm_out !== 4'hF) begin errors++; $display("FAIL reset_pwm got=%b want=1111", pwm_out); end
    rst = 1'b0;
    model_reset();
    tick();
    checks++; if (daddr !== 7'h16) begin errors++; $display("FAIL reset_daddr got=%h want=16", daddr); end
  endtask

  task automatic test_scan;
    logic [15:0] d;
    logic [6:0]  a, exp_a;
    int          w, dly;
    bit          st;
    for (int r = 0; r < 5; r++) begin
      d     = (r == 0) ? 16'hA5C0 : 16'($urandom);
      dly   = (r == 0) ? 3 : int'($urandom_range(1, 6));
      exp_a = addr_tab[model_idx];
      run_txn(d, dly, 1'b1, 1'b0, a, w);
      model_cap(d, st);
      $display("scan txn %0d addr=%h dout=%h valid=%b data=%h ch=%0d", r, a, d, sample_valid, sample_data, sample_ch);
      checks++; if (w !== 1) begin errors++; $display("FAIL scan_den_width got=%0d want=1", w); end
      checks++; if (a !== exp_a) begin errors++; $display("FAIL scan_daddr got=%h want=%h", a, exp_a); end
      checks++; if (sample_valid !== st) begin errors++; $display("FAIL scan_valid got=%b want=%b", sample_valid, st); end
      if (st) begin
        checks++; if (sample_data !== model_data) begin errors++; $display("FAIL scan_data got=%h want=%h", sample_data, model_data); end
        checks++; if (int'(sample_ch) !== model_ch) begin errors++; $display("FAIL scan_ch got=%0d want=%0d", sample_ch, model_ch); end
      end
`ifndef XADC_SCAN_AVG_EN
      if (r == 0) begin
        checks++; if (sample_data !== 8'hA5) begin errors++; $display("FAIL scan_first_data got=%h want=a5", sample_data); end
      end
`endif
      tick();
      checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL scan_valid_width got=%b want=0", sample_valid); end
    end
  endtask

  task automatic test_timeout;
    logic [15:0] d;
    logic [6:0]  a, exp_a;
    int          w, t0;
    bit          st;
    exp_a = addr_tab[model_idx];
    t0 = to_cnt;
    run_txn(16'h0, 0, 1'b0, 1'b0, a, w);
    repeat (TIMEOUT - 1) tick();
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL tmo_early got=%b want=0", timeout_err); end
    tick();
    $display("timeout txn addr=%h timeout_err=%b", a, timeout_err);
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL tmo_strobe got=%b want=1", timeout_err); end
    checks++; if (sample_data !== model_data) begin errors++; $display("FAIL tmo_data got=%h want=%h", sample_data, model_data); end
    tick();
    d = 16'($urandom);
    run_txn(d, 2, 1'b1, 1'b0, a, w);
    model_cap(d, st);
    $display("retry txn addr=%h dout=%h valid=%b", a, d, sample_valid);
    checks++; if (a !== exp_a) begin errors++; $display("FAIL tmo_retry_addr got=%h want=%h", a, exp_a); end
    checks++; if (sample_valid !== st) begin errors++; $display("FAIL tmo_retry_valid got=%b want=%b", sample_valid, st); end
    // drdy arriving on the final wait cycle is a capture, not a timeout.
    d = 16'($urandom);
    run_txn(d, TIMEOUT, 1'b1, 1'b0, a, w);
    model_cap(d, st);
    $display("edge txn addr=%h dout=%h valid=%b", a, d, sample_valid);
    checks++; if (sample_valid !== st) begin errors++; $display("FAIL tmo_edge_valid got=%b want=%b", sample_valid, st); end
    tick();
    checks++; if (to_cnt !== t0 + 1) begin errors++; $display("FAIL tmo_edge_count got=%0d want=%0d", to_cnt, t0 + 1); end
  endtask

  task automatic test_eoc_ignore;
    logic [15:0] d;
    logic [6:0]  a;
    int          w, d0, s0;
    bit          st;
    d0 = den_cnt;
    d  = 16'($urandom);
    run_txn(d, 8, 1'b1, 1'b1, a, w);
    model_cap(d, st);
    $display("eoc-spam txn addr=%h dout=%h valid=%b", a, d, sample_valid);
    checks++; if (sample_valid !== st) begin errors++; $display("FAIL eoc_valid got=%b want=%b", sample_valid, st); end
    repeat (4) tick();
    checks++; if (den_cnt !== d0 + 1) begin errors++; $display("FAIL eoc_den_count got=%0d want=%0d", den_cnt, d0 + 1); end
    s0 = sv_cnt;
    drdy = 1'b1; dout = 16'($urandom);
    tick();
    drdy = 1'b0;
    repeat (3) tick();
    checks++; if (sv_cnt !== s0) begin errors++; $display("FAIL idle_drdy_valid got=%0d want=%0d", sv_cnt, s0); end
    checks++; if (sample_data !== model_data) begin errors++; $display("FAIL idle_drdy_data got=%h want=%h", sample_data, model_data); end
  endtask

  task automatic test_random;
    logic [15:0] d;
    logic [6:0]  a, exp_a;
    int          w;
    bit          st, send;
    for (int n = 0; n < 30; n++) begin
      d     = 16'($urandom);
      send  = ($urandom_range(0, 9) != 0);
      exp_a = addr_tab[model_idx];
      run_txn(d, int'($urandom_range(1, 20)), send, 1'($urandom_range(0, 1)), a, w);
      checks++; if (a !== exp_a) begin errors++; $display("FAIL rnd_addr got=%h want=%h", a, exp_a); end
      if (send) begin
        model_cap(d, st);
        $display("rnd txn %0d addr=%h dout=%h valid=%b data=%h", n, a, d, sample_valid, sample_data);
        checks++; if (sample_valid !== st) begin errors++; $display("FAIL rnd_valid got=%b want=%b", sample_valid, st); end
        checks++; if (sample_data !== model_data) begin errors++; $display("FAIL rnd_data got=%h want=%h", sample_data, model_data); end
        checks++; if (int'(sample_ch) !== model_ch) begin errors++; $display("FAIL rnd_ch got=%0d want=%0d", sample_ch, model_ch); end
      end else begin
        repeat (TIMEOUT) tick();
        $display("rnd txn %0d addr=%h timeout_err=%b", n, a, timeout_err);
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL rnd_timeout got=%b want=1", timeout_err); end
      end
      repeat ($urandom_range(1, 3)) begin
        drdy = 1'($urandom_range(0, 1));
        tick();
      end
      drdy = 1'b0;
    end
  endtask

  task automatic wait_periods(input int k);
    int p0, g;
    p0 = periods; g = 0;
    while (periods < p0 + k && g < 300 * k) begin tick(); g++; end
    checks++; if (periods < p0 + k) begin errors++; $display("FAIL pwm_period_wait got=%0d want=%0d", periods - p0, k); end
  endtask

  task automatic test_pwm;
    logic [15:0] d;
    logic [6:0]  a;
    int          w, g;
    bit          st;
    logic [7:0]  v;
    do_reset();
    d = {8'h40, 8'($urandom)};
    run_txn(d, 2, 1'b1, 1'b0, a, w);
    model_cap(d, st);
    wait_periods(2);
    $display("pwm period ch0=%0d ch1=%0d ch2=%0d ch3=%0d", last_hi[0], last_hi[1], last_hi[2], last_hi[3]);
    for (int i = 0; i < NUM_CH; i++) begin
      checks++; if (last_hi[i] !== last_exp[i]) begin errors++; $display("FAIL pwm_on_ch%0d got=%0d want=%0d", i, last_hi[i], last_exp[i]); end
    end
`ifndef XADC_SCAN_AVG_EN
    checks++; if (last_hi[0] !== 65) begin errors++; $display("FAIL pwm_0x40 got=%0d want=65", last_hi[0]); end
`endif
    g = 0;
    while (tb_pwm != 8'd64 && g < 300) begin tick(); g++; end
    v = 8'($urandom_range(2, 250));
    d = {v, 8'h00};
    run_txn(d, 2, 1'b1, 1'b0, a, w);
    model_cap(d, st);
    $display("pwm mid-period txn addr=%h dout=%h", a, d);
    wait_periods(1);
    checks++; if (last_hi[1] !== 1) begin errors++; $display("FAIL pwm_mid_hold got=%0d want=1", last_hi[1]); end
    wait_periods(1);
    checks++; if (last_hi[1] !== last_exp[1]) begin errors++; $display("FAIL pwm_mid_next got=%0d want=%0d", last_hi[1], last_exp[1]); end
`ifndef XADC_SCAN_AVG_EN
    checks++; if (last_hi[1] !== int'(v) + 1) begin errors++; $display("FAIL pwm_new_duty got=%0d want=%0d", last_hi[1], int'(v) + 1); end
`endif
  endtask

  task automatic test_mid_reset;
    logic [6:0] a;
    int         w, s0;
    do_reset();
    run_txn(16'h0, 0, 1'b0, 1'b0, a, w);
    run_txn(16'h0, 0, 1'b0, 1'b0, a, w);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    s0 = sv_cnt;
    checks++; if (den !== 1'b0) begin errors++; $display("FAIL mrst_den got=%b want=0", den); end
    drdy = 1'b1; dout = 16'hFFFF;
    tick();
    drdy = 1'b0;
    repeat (3) tick();
    $display("mid-reset txn daddr=%h valid_count=%0d", daddr, sv_cnt - s0);
    checks++; if (sv_cnt !== s0) begin errors++; $display("FAIL mrst_late_drdy got=%0d want=%0d", sv_cnt, s0); end
    checks++; if (sample_data !== 8'h00) begin errors++; $display("FAIL mrst_data got=%h want=00", sample_data); end
    checks++; if (daddr !== addr_tab[0]) begin errors++; $display("FAIL mrst_daddr got=%h want=%h", daddr, addr_tab[0]); end
  endtask

`ifdef XADC_SCAN_AVG_EN
  task automatic test_avg;
    logic [7:0]  vals [4];
    logic [15:0] d;
    logic [6:0]  a;
    int          w, s0;
    bit          st;
    vals = '{8'd10, 8'd20, 8'd30, 8'd41};
    do_reset();
    s0 = sv_cnt;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        d = (c == 0) ? {vals[r], 8'h00} : 16'($urandom);
        run_txn(d, 2, 1'b1, 1'b0, a, w);
        model_cap(d, st);
        $display("avg txn r=%0d ch=%0d dout=%h valid=%b data=%h", r, c, d, sample_valid, sample_data);
        checks++; if (sample_valid !== st) begin errors++; $display("FAIL avg_valid got=%b want=%b", sample_valid, st); end
        if (c == 0 && r == 3) begin
          checks++; if (sample_data !== 8'd25) begin errors++; $display("FAIL avg_mean got=%0d want=25", sample_data); end
        end
      end
    end
    tick();
    checks++; if (sv_cnt !== s0 + NUM_CH) begin errors++; $display("FAIL avg_strobes got=%0d want=%0d", sv_cnt - s0, NUM_CH); end
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_scan();
    test_timeout();
    test_eoc_ignore();
    test_random();
    test_pwm();
    test_mid_reset();
`ifdef XADC_SCAN_AVG_EN
    test_avg();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
